fp_norm_round: RTL and testbench
================================

Name: fp_norm_round

Overview:
- Post-adder normalise/round/pack stage of the FP adder datapath.
- Consumes the raw 24-bit significand sum, carry-out, result sign, pre-normalisation exponent and guard/round/sticky bits.
- Normalises iteratively (one bit per cycle), rounds to nearest-even, and packs an IEEE-754 single-precision word with exception flags.
- Upstream handshake is REQ/ACK; downstream handshake is Dataout_valid/Out_ack.

Parameters:
- EXP_W, 8, biased exponent width.
- MANT_W, 24, significand width including hidden bit.

Ports:
- CLK  in  1  single clock, all logic on posedge.
- RST  in  1  reset; synchronous, active-high.
- REQ  in  1  request; upstream holds it high with stable inputs until ACK.
- Sign  in  1  result sign.
- Exp  in  EXP_W  biased exponent of the larger operand, range 1..254.
- Mant  in  MANT_W  significand sum from adder.
- Carry  in  1  adder carry-out.
- Grs  in  3  {guard, round, sticky} from alignment.
- ACK  out  1  one-cycle pulse: inputs captured.
- Busy  out  1  high whenever state != IDLE.
- Dataout  out  32  packed result {sign, exp[7:0], frac[22:0]}.
- Dataout_valid  out  1  result valid; held until Out_ack.
- Out_ack  in  1  downstream accepts the result.
- Exc  out  3  [0] overflow, [1] underflow, [2] exact zero; valid with Dataout_valid.

Behaviour:
- Reset: RST sampled high sends the FSM to IDLE and zeroes Dataout, Dataout_valid, Exc, ACK and Busy. Mid-operation reset discards the in-flight result with no ACK and no valid.
- FSM states: IDLE, NORM, ROUND, DONE.
- IDLE: when REQ is high at an edge, capture all inputs into working registers m, e, s, c, {G,R,S}. Go to NORM. ACK is high for exactly the following cycle.
- NORM (one action per edge, evaluated in this priority):
  - c=1: right shift. m <= {1, m[23:1]}; G <= m[0]; R <= G; S <= R|S; e <= e+1; c <= 0.
  - Value is zero (m, G, R, S and c all 0): go to ROUND with the zero flag set.
  - m[23]=0 and e>1: left shift. m <= {m[22:0], G}; G <= R; R <= 0; S unchanged; e <= e-1.
  - m[23]=0 and e==1: set the underflow flag, go to ROUND.
  - Otherwise: go to ROUND.
- ROUND: round to nearest-even. Increment when G & (R|S|m[0]). If the increment overflows m, then m <= 0x800000 and e <= e+1. Go to DONE.
- DONE: Dataout_valid=1 with Dataout and Exc stable. When Out_ack is sampled high, clear Dataout_valid and go to IDLE.
  - A REQ that is high in the same cycle is not captured until the next edge. There is no back-to-back bypass.
- Latency: k = number of shift cycles (0..23; 1 when c=1). Dataout_valid rises 2+k cycles after the capture edge.
- Packing rules:
  - e reaches 255 (after a shift or after rounding): Dataout = {s, 0xFF, 0}, Exc[0]=1.
  - Underflow: Dataout = {s, 31'b0} (flush to zero), Exc[1]=1.
  - Exact zero: Dataout = 32'h0 (sign forced +), Exc[2]=1.
  - Otherwise: Dataout = {s, e[7:0], m[22:0]}, Exc=0.
- REQ while Busy is ignored. Upstream keeps REQ asserted and it is captured on return to IDLE.
- Out_ack outside DONE has no effect.
- Exp=0 or 255 at input is outside the contract; the upstream exception path handles special operands.

Decomposition:
- Package fp_pkg holds:
  - EXP_W, MANT_W, BIAS=127, EXP_MAX=255.
  - Exc bit indices EXC_OVF=0, EXC_UNF=1, EXC_ZERO=2.
  - State enum norm_state_t {IDLE, NORM, ROUND, DONE}.
  - Packed struct fp32_t {sign, exp, frac}.
- One natural combinational sub-module, fp_round_rne: inputs m and G/R/S; outputs the rounded m and a mantissa-overflow flag. The FSM, shifter and exponent tracking stay in fp_norm_round.

Test Plan:
- Carry normalise (2.75+5.5): Sign=0, Exp=0x81, Mant=0xB00000+0x580000 → Carry=1, Mant=0x080000, Grs=000 → Dataout=0x41040000 (8.25), Exc=000, valid 3 cycles after capture.
- Left-shift normalise (5.5−2.75): Exp=0x81, Mant=0x580000, Carry=0, Grs=000 → Dataout=0x40300000 (2.75), k=1.
- Rounding carry: Exp=0x7F, Mant=0xFFFFFF, Grs=101 → Dataout=0x40000000.
- Ties-to-even:
  - Mant=0x800001, Exp=0x7F, Grs=100 → 0x3F800002.
  - Mant=0x800000, Exp=0x7F, Grs=100 → 0x3F800000.
- Exceptions:
  - Exp=0xFE, Carry=1, Mant=0 → 0x7F800000, Exc=001.
  - Exp=1, Mant=0x400000 → 0x00000000, Exc=010.
  - Sign=1, Mant=0, Grs=000 → 0x00000000, Exc=100.
- Handshake and reset:
  - RST asserted in NORM → next cycle all outputs 0, no ACK.
  - REQ held through DONE with Out_ack late → Dataout_valid held stable; next capture occurs one cycle after Out_ack.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants, state encoding and packed single-precision layout for the
// FP adder normalise/round stage.
package fp_pkg;
  localparam int EXP_W   = 8;
  localparam int MANT_W  = 24;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam int EXC_OVF  = 0;
  localparam int EXC_UNF  = 1;
  localparam int EXC_ZERO = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } norm_state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-2:0] frac;
  } fp32_t;
endpackage

// File: rtl/fp_norm_round_if.sv
// Upstream REQ/ACK and downstream Dataout_valid/Out_ack bundle for fp_norm_round.
interface fp_norm_round_if;
  import fp_pkg::*;

  logic              REQ;
  logic              Sign;
  logic [EXP_W-1:0]  Exp;
  logic [MANT_W-1:0] Mant;
  logic              Carry;
  logic [2:0]        Grs;
  logic              ACK;
  logic              Busy;
  logic [31:0]       Dataout;
  logic              Dataout_valid;
  logic              Out_ack;
  logic [2:0]        Exc;

  modport master (
    output REQ, Sign, Exp, Mant, Carry, Grs, Out_ack,
    input  ACK, Busy, Dataout, Dataout_valid, Exc
  );

  modport slave (
    input  REQ, Sign, Exp, Mant, Carry, Grs, Out_ack,
    output ACK, Busy, Dataout, Dataout_valid, Exc
  );
endinterface

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a normalised significand; a carry out of the top
// bit returns 1.000 and flags that the exponent must be bumped.
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [MANT_W-1:0] m_in,
  input  logic [2:0]        grs,
  output logic [MANT_W-1:0] m_out,
  output logic              ovf
);
  logic              inc;
  logic [MANT_W:0]   sum;

  assign inc   = grs[2] & (grs[1] | grs[0] | m_in[0]);
  assign sum   = {1'b0, m_in} + {{MANT_W{1'b0}}, inc};
  assign ovf   = sum[MANT_W];
  assign m_out = ovf ? {1'b1, {(MANT_W-1){1'b0}}} : sum[MANT_W-1:0];
endmodule

// File: rtl/fp_norm_round.sv
// Iterative normalise (one bit per cycle), RNE round and IEEE-754 single pack
// stage behind the FP adder.
module fp_norm_round
  import fp_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  fp_norm_round_if.slave   bus
);
  localparam int EW = EXP_W + 2;
  localparam logic [EW-1:0] E_ONE = EW'(1);
  localparam logic [EW-1:0] E_MAX = EW'(EXP_MAX);

  norm_state_t       state, state_nxt;
  logic [MANT_W-1:0] m;
  logic [EW-1:0]     e;
  logic              s, c, g, r, st;
  logic              zero_f, unf_f;
  logic              is_zero;

  logic [MANT_W-1:0] m_rnd;
  logic              m_ovf;
  logic [EW-1:0]     e_rnd;
  fp32_t             pack;
  logic [2:0]        pack_exc;

  logic              ack;
  logic              valid;
  logic [31:0]       dout;
  logic [2:0]        exc;

  assign is_zero = ~|{m, g, r, st, c};

  fp_round_rne u_round (
    .m_in  (m),
    .grs   ({g, r, st}),
    .m_out (m_rnd),
    .ovf   (m_ovf)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.REQ) state_nxt = NORM;
      NORM:  if (!c && (is_zero || m[MANT_W-1] || e <= E_ONE)) state_nxt = ROUND;
      ROUND: state_nxt = DONE;
      DONE:  if (bus.Out_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Zero and underflow override the exponent check; an exponent of 255 from
  // either the carry shift or the rounding bump saturates to infinity.
  always_comb begin
    e_rnd    = e + {{(EW-1){1'b0}}, m_ovf};
    pack     = '0;
    pack_exc = '0;
    if (zero_f) begin
      pack_exc[EXC_ZERO] = 1'b1;
    end else if (unf_f) begin
      pack.sign          = s;
      pack_exc[EXC_UNF]  = 1'b1;
    end else if (e_rnd >= E_MAX) begin
      pack.sign          = s;
      pack.exp           = '1;
      pack_exc[EXC_OVF]  = 1'b1;
    end else begin
      pack.sign = s;
      pack.exp  = e_rnd[EXP_W-1:0];
      pack.frac = m_rnd[MANT_W-2:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ack    <= 1'b0;
      valid  <= 1'b0;
      dout   <= '0;
      exc    <= '0;
      m      <= '0;
      e      <= '0;
      s      <= 1'b0;
      c      <= 1'b0;
      g      <= 1'b0;
      r      <= 1'b0;
      st     <= 1'b0;
      zero_f <= 1'b0;
      unf_f  <= 1'b0;
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.REQ) begin
            m      <= bus.Mant;
            e      <= {2'b00, bus.Exp};
            s      <= bus.Sign;
            c      <= bus.Carry;
            {g, r, st} <= bus.Grs;
            zero_f <= 1'b0;
            unf_f  <= 1'b0;
            ack    <= 1'b1;
          end
        end
        NORM: begin
          if (c) begin
            m  <= {1'b1, m[MANT_W-1:1]};
            g  <= m[0];
            r  <= g;
            st <= r | st;
            e  <= e + E_ONE;
            c  <= 1'b0;
          end else if (is_zero) begin
            zero_f <= 1'b1;
          end else if (!m[MANT_W-1] && e > E_ONE) begin
            m <= {m[MANT_W-2:0], g};
            g <= r;
            r <= 1'b0;
            e <= e - E_ONE;
          end else if (!m[MANT_W-1]) begin
            unf_f <= 1'b1;
          end
        end
        ROUND: begin
          m     <= m_rnd;
          e     <= e_rnd;
          dout  <= pack;
          exc   <= pack_exc;
          valid <= 1'b1;
        end
        DONE: begin
          if (bus.Out_ack) valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.ACK           = ack;
  assign bus.Busy          = (state != IDLE);
  assign bus.Dataout       = dout;
  assign bus.Dataout_valid = valid;
  assign bus.Exc           = exc;
endmodule

// File: tb/tb_fp_norm_round.sv
// Directed-vector bench for fp_norm_round: normalise, rounding, exceptions,
// latency, mid-operation reset and late Out_ack with REQ held.
module tb_fp_norm_round;
  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   fails  = 0;

  fp_norm_round_if bus ();

  fp_norm_round dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic sg, input logic [7:0] ex, input logic [23:0] mt,
                       input logic cy, input logic [2:0] gr);
    bus.Sign  = sg;
    bus.Exp   = ex;
    bus.Mant  = mt;
    bus.Carry = cy;
    bus.Grs   = gr;
  endtask

  // Waits for Dataout_valid after a capture edge; returns the cycle count.
  task automatic wait_valid(input string tag, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
      if (cyc == 1) check({tag, "_ack_pulse"}, 32'(bus.ACK), 32'd0);
    end while (!bus.Dataout_valid && cyc < 40);
  endtask

  task automatic run_vec(input string tag, input logic sg, input logic [7:0] ex,
                         input logic [23:0] mt, input logic cy, input logic [2:0] gr,
                         input logic [31:0] xd, input logic [2:0] xe, input int xlat);
    int cyc;
    drive(sg, ex, mt, cy, gr);
    bus.REQ = 1'b1;
    step();
    check({tag, "_ack"}, 32'(bus.ACK), 32'd1);
    bus.REQ = 1'b0;
    wait_valid(tag, cyc);
    check({tag, "_lat"}, 32'(cyc), 32'(xlat));
    check({tag, "_data"}, bus.Dataout, xd);
    check({tag, "_exc"}, 32'(bus.Exc), 32'(xe));
    bus.Out_ack = 1'b1;
    step();
    bus.Out_ack = 1'b0;
    check({tag, "_vld_clr"}, 32'(bus.Dataout_valid), 32'd0);
    check({tag, "_idle"}, 32'(bus.Busy), 32'd0);
  endtask

  initial begin
    int  cyc;
    bit  saw_valid;

    RST = 1'b1;
    bus.REQ = 1'b0;
    bus.Out_ack = 1'b0;
    drive(1'b0, 8'h00, 24'h0, 1'b0, 3'b000);
    repeat (3) step();
    check("rst_data", bus.Dataout, 32'h0);
    check("rst_valid", 32'(bus.Dataout_valid), 32'd0);
    check("rst_ack", 32'(bus.ACK), 32'd0);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_exc", 32'(bus.Exc), 32'd0);
    RST = 1'b0;
    step();

    run_vec("carry",   1'b0, 8'h81, 24'h080000, 1'b1, 3'b000, 32'h41040000, 3'b000, 3);
    run_vec("lshift",  1'b0, 8'h81, 24'h580000, 1'b0, 3'b000, 32'h40300000, 3'b000, 3);
    run_vec("rnd_cy",  1'b0, 8'h7F, 24'hFFFFFF, 1'b0, 3'b101, 32'h40000000, 3'b000, 2);
    run_vec("tie_odd", 1'b0, 8'h7F, 24'h800001, 1'b0, 3'b100, 32'h3F800002, 3'b000, 2);
    run_vec("tie_evn", 1'b0, 8'h7F, 24'h800000, 1'b0, 3'b100, 32'h3F800000, 3'b000, 2);
    run_vec("neg_lsh", 1'b1, 8'h7F, 24'h000100, 1'b0, 3'b000, 32'hB8000000, 3'b000, 17);
    run_vec("ovf",     1'b0, 8'hFE, 24'h000000, 1'b1, 3'b000, 32'h7F800000, 3'b001, 3);
    run_vec("unf",     1'b0, 8'h01, 24'h400000, 1'b0, 3'b000, 32'h00000000, 3'b010, 2);
    run_vec("zero",    1'b1, 8'h40, 24'h000000, 1'b0, 3'b000, 32'h00000000, 3'b100, 2);

    // Reset two cycles into a long left-shift sequence.
    drive(1'b0, 8'h7F, 24'h000100, 1'b0, 3'b000);
    bus.REQ = 1'b1;
    step();
    bus.REQ = 1'b0;
    step();
    check("mid_busy", 32'(bus.Busy), 32'd1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("mid_rst_busy", 32'(bus.Busy), 32'd0);
    check("mid_rst_ack", 32'(bus.ACK), 32'd0);
    check("mid_rst_vld", 32'(bus.Dataout_valid), 32'd0);
    check("mid_rst_data", bus.Dataout, 32'h0);
    check("mid_rst_exc", 32'(bus.Exc), 32'd0);
    saw_valid = 1'b0;
    repeat (25) begin
      step();
      if (bus.Dataout_valid || bus.ACK) saw_valid = 1'b1;
    end
    check("mid_rst_quiet", 32'(saw_valid), 32'd0);

    // REQ held through DONE, Out_ack late.
    drive(1'b0, 8'h81, 24'h080000, 1'b1, 3'b000);
    bus.REQ = 1'b1;
    step();
    check("hold_ack", 32'(bus.ACK), 32'd1);
    wait_valid("hold", cyc);
    check("hold_lat", 32'(cyc), 32'd3);
    repeat (4) begin
      step();
      check("hold_vld", 32'(bus.Dataout_valid), 32'd1);
      check("hold_data", bus.Dataout, 32'h41040000);
      check("hold_noack", 32'(bus.ACK), 32'd0);
    end
    bus.Out_ack = 1'b1;
    step();
    bus.Out_ack = 1'b0;
    check("hold_vld_clr", 32'(bus.Dataout_valid), 32'd0);
    check("hold_no_cap", 32'(bus.ACK), 32'd0);
    step();
    check("hold_recap", 32'(bus.ACK), 32'd1);
    bus.REQ = 1'b0;
    wait_valid("hold2", cyc);
    check("hold2_lat", 32'(cyc), 32'd3);
    check("hold2_data", bus.Dataout, 32'h41040000);
    bus.Out_ack = 1'b1;
    step();
    bus.Out_ack = 1'b0;
    check("hold2_vld_clr", 32'(bus.Dataout_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
